// File: rtl/lsu_mem_master.sv
// Multi-cycle load/store unit bridging core byte/half/word requests onto a word-only data memory.
// Sub-word stores are done as read-modify-write; misaligned or out-of-range requests never touch memory.
module lsu_mem_master #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] addr_r, wdata_r, rbuf_r;
    logic [1:0]  size_r;
    logic        we_r, uns_r, err_r;
    logic        accept_s, req_err_s;

    function automatic logic check_err(input logic [31:0] a, input logic [1:0] sz);
        logic e;
        case (sz)
            2'b00:   e = 1'b0;
            2'b01:   e = a[0];
            2'b10:   e = (a[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | ({2'b00, a[31:2]} >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                                input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = old_w;
        case (sz)
            2'b00:   r[{a, 3'b000} +: 8]     = wd[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign req_err_s = check_err(req_addr, req_size);

    // Next-state and output decode; outputs depend only on state and latched fields.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0000_0000;
        mem_we     = 1'b0;
        mem_wd     = 32'h0000_0000;
        mem_a      = {addr_r[31:2], 2'b00};
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_err_s) begin
                        state_s = RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_s = WR;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                state_s = we_r ? WR : RESP;
            end
            WR: begin
                mem_we  = 1'b1;
                mem_wd  = store_merge(rbuf_r, wdata_r, addr_r[1:0], size_r);
                state_s = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_r;
                if (err_r || we_r) begin
                    resp_rdata = 32'h0000_0000;
                end else begin
                    resp_rdata = load_extract(rbuf_r, addr_r[1:0], size_r, uns_r);
                end
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request fields latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            size_r  <= 2'b00;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            size_r  <= req_size;
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            err_r   <= req_err_s;
        end
    end

    // Read buffer captures the addressed word during RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_r <= 32'h0000_0000;
        end else if (state_r == RD) begin
            rbuf_r <= mem_rd;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: attached word memory, transaction-level model checked every cycle,
// plus literal expectations from the directed test list.
module tb_lsu_mem_master;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    logic [31:0] tmem [64];
    logic [31:0] mm [64];

    lsu_mem_master #(.DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a),
        .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) begin
            tmem[i] = 32'h0;
            mm[i]   = 32'h0;
        end
    end

    // Attached memory: combinational read, write on posedge.
    assign mem_rd = (mem_a[31:8] == 24'h0) ? tmem[mem_a[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && (mem_a[31:8] == 24'h0)) tmem[mem_a[7:2]] <= mem_wd;
    end

    // Transaction prediction from the current request and the model memory.
    logic [31:0] p_wi, p_cur, p_sh, p_mask, p_val, p_rdata, p_wd, p_lat, p_wec;
    logic        p_err;
    always_comb begin
        p_wi   = {2'b00, req_addr[31:2]};
        p_err  = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'd0) || (p_wi >= 32'd64);
        p_cur  = p_err ? 32'h0 : mm[p_wi[5:0]];
        p_sh   = (req_size == 2'd0) ? {27'd0, req_addr[1:0], 3'd0} :
                 (req_size == 2'd1) ? {27'd0, req_addr[1], 4'd0} : 32'd0;
        p_mask = (req_size == 2'd0) ? 32'hFF : (req_size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        p_val  = (p_cur >> p_sh) & p_mask;
        if (!req_unsigned && req_size != 2'd2 && (p_val & ((p_mask + 32'd1) >> 1)) != 32'd0)
            p_val = p_val | ~p_mask;
        p_rdata = (p_err || req_we) ? 32'h0 : p_val;
        p_wd    = (p_cur & ~(p_mask << p_sh)) | ((req_wdata & p_mask) << p_sh);
        p_lat   = p_err ? 32'd1 : (req_we ? ((req_size == 2'd2) ? 32'd2 : 32'd3) : 32'd2);
        p_wec   = (p_err || !req_we) ? 32'd0 : p_lat - 32'd1;
    end

    logic        m_busy, m_err;
    logic [31:0] m_k, m_lat, m_wec, m_rdata, m_wd, m_a, m_wi;

    // Model state: k counts cycles since acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_k    <= 32'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_k     <= 32'd1;
                m_err   <= p_err;
                m_lat   <= p_lat;
                m_wec   <= p_wec;
                m_rdata <= p_rdata;
                m_wd    <= p_wd;
                m_a     <= {req_addr[31:2], 2'b00};
                m_wi    <= p_wi;
            end
        end else if (m_k >= m_lat) begin
            if (resp_ready) begin
                m_busy <= 1'b0;
                m_k    <= 32'd0;
            end
        end else begin
            if (m_k == m_wec) mm[m_wi[5:0]] <= m_wd;
            m_k <= m_k + 32'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!m_busy) begin
                chk1("idle_ready", req_ready, 1'b1);
                chk1("idle_rvalid", resp_valid, 1'b0);
                chk1("idle_we", mem_we, 1'b0);
            end else if (m_k < m_lat) begin
                chk1("busy_ready", req_ready, 1'b0);
                chk1("busy_rvalid", resp_valid, 1'b0);
                chk1("busy_we", mem_we, m_k == m_wec);
                if (m_k == m_wec) begin
                    chk("wr_addr", mem_a, m_a);
                    chk("wr_data", mem_wd, m_wd);
                end
            end else begin
                chk1("resp_valid", resp_valid, 1'b1);
                chk1("resp_ready_low", req_ready, 1'b0);
                chk1("resp_we", mem_we, 1'b0);
                chk1("resp_err", resp_err, m_err);
                chk("resp_rdata", resp_rdata, m_rdata);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk1("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic get_resp(input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk1("resp_timeout", 1'b0, 1'b1);
        last_rdata = resp_rdata;
        last_err   = resp_err;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] exp);
        issue(1'b0, sz, uns, a, 32'h0);
        get_resp(0);
        chk("load_value", last_rdata, exp);
        chk1("load_err", last_err, 1'b0);
    endtask

    task automatic bad(input logic we, input logic [1:0] sz, input logic [31:0] a);
        issue(we, sz, 1'b0, a, 32'hFFFF_FFFF);
        get_resp(0);
        chk1("err_flag", last_err, 1'b1);
        chk("err_rdata", last_rdata, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        #3;
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_rvalid", resp_valid, 1'b0);
        chk1("rst_err", resp_err, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_wd", mem_wd, 32'h0);
        chk("rst_a", mem_a, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        get_resp(0);
        chk1("sw_err", last_err, 1'b0);
        chk("sw_mem", tmem[4], 32'hDEAD_BEEF);
        ld(2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);

        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA55);
        get_resp(0);
        chk("sb_mem", tmem[4], 32'hDEAD_55EF);
        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_1234);
        get_resp(0);
        chk("sh_mem", tmem[4], 32'h1234_55EF);
        chk("sh_model", mm[4], 32'h1234_55EF);

        issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF_7F01);
        get_resp(0);
        ld(2'd0, 1'b0, 32'h2, 32'hFFFF_FFFF);
        ld(2'd0, 1'b1, 32'h2, 32'h0000_00FF);
        ld(2'd1, 1'b0, 32'h2, 32'hFFFF_80FF);
        ld(2'd1, 1'b1, 32'h0, 32'h0000_7F01);
        ld(2'd0, 1'b0, 32'h0, 32'h0000_0001);
        ld(2'd0, 1'b0, 32'h3, 32'hFFFF_FF80);
        ld(2'd0, 1'b0, 32'h1, 32'h0000_007F);

        bad(1'b0, 2'd2, 32'h6);
        bad(1'b1, 2'd1, 32'h3);
        bad(1'b0, 2'd3, 32'h0);
        bad(1'b0, 2'd2, 32'h100);
        bad(1'b1, 2'd0, 32'h100);
        chk("err_no_write", tmem[0], 32'h80FF_7F01);

        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        req_we = 1'b0; req_size = 2'd1; req_unsigned = 1'b1; req_addr = 32'h12;
        req_valid = 1'b1;
        get_resp(5);
        chk("bp_first", last_rdata, 32'h1234_55EF);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        get_resp(0);
        chk("bp_second", last_rdata, 32'h0000_1234);

        issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h0000_0077);
        @(posedge clk);
        #1 chk1("pre_rst_we", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_we", mem_we, 1'b0);
        chk1("mid_rst_rvalid", resp_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_rst_word", tmem[4], 32'h1234_55EF);
        chk1("post_rst_ready", req_ready, 1'b1);
        ld(2'd2, 1'b0, 32'h10, 32'h1234_55EF);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Multi-cycle load/store unit between the MIPS core datapath and the word-only data memory (64 x 32-bit, combinational read, write on posedge clk).
- Converts core byte/halfword/word load and store requests into word accesses, with read-modify-write for sub-word stores.
- Extracts and sign/zero-extends sub-word loads.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached data memory; word index must be < DEPTH.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as an error.
- req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for sub-word stores.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or had size 11.
- mem_a  out  32  memory byte address, always {addr[31:2],2'b00}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data (combinational from mem_a).

Behaviour:
- Byte lanes are little-endian: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h].
- Reset (async, rst_n=0):
  - State goes to IDLE; all latched request fields and the read buffer clear to 0.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_wd=0, mem_a=0.
  - Reset asserted mid-operation aborts it: mem_we drops immediately, no partial write, no response.
- FSM states: IDLE, RD, WR, RESP. All outputs are decoded from the state register and latched fields only; no req_* to mem_* combinational path.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, size, we, unsigned, wdata.
  - Error check: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH.
  - If error: go to RESP with err=1. No memory access.
  - Else word store: go to WR.
  - Else (load, or sub-word store): go to RD.
- RD:
  - mem_a=word address, mem_we=0.
  - Capture mem_rd into the read buffer at the clock edge.
  - Go to RESP for a load, WR for a store.
- WR:
  - mem_we=1 for exactly one cycle.
  - mem_wd = wdata for a word store.
  - For a sub-word store, mem_wd = read buffer with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other lanes are unchanged.
  - Go to RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready: go to IDLE.
  - A new request can be accepted in the cycle after the handshake, not in the handshake cycle.
- Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half); extend per the unsigned flag; word loads pass through.
- Latency, with accept at cycle N:
  - Error: resp_valid at N+1.
  - Load and word store: resp_valid at N+2.
  - Sub-word store: resp_valid at N+3.
  - Word store: mem_we high in N+1.
  - Sub-word store: mem_we high in N+2.
- req_valid while not IDLE is ignored; the core must hold its request.
- resp_ready while not in RESP is ignored.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF, size 10 -> mem_we high 1 cycle at N+1, mem_a=0x10; resp at N+2, err=0. Load 0x10 -> resp_rdata=0xDEADBEEF at N+2.
- Sub-word RMW: word 0x10 = 0xDEADBEEF; sb addr 0x11 data 0x55 -> mem_wd=0xDEAD55EF at N+2. sh addr 0x12 data 0x1234 -> word becomes 0x123455EF.
- Extension: word 0x80FF7F01. lb 0x2 -> 0xFFFFFFFF. lbu 0x2 -> 0x000000FF. lh 0x2 -> 0xFFFF80FF. lhu 0x0 -> 0x00007F01. lb 0x0 -> 0x00000001.
- Errors: lw 0x6, sh 0x3, size 11, and lw 0x100 (index 64 >= DEPTH) -> each gives resp_err=1 at N+1, resp_rdata=0, mem_we never asserted.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata stable, req_ready=0 throughout. Request presented meanwhile is accepted only after the handshake.
- Reset mid-op: deassert rst_n during WR of a sub-word store -> mem_we falls immediately, target word unchanged, resp_valid=0, req_ready=1 after release.
